logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
// - Parametrised, pipelined bitwise logic unit; successor to the single-bit AND/OR/XOR/NOT/NAND gate blocks.
// - Applies one of eight bitwise ops to WIDTH-bit operands.
// - Results travel through a STAGES-deep valid/ready pipeline with full backpressure.
// - Produces zero/parity flags and a saturating count of delivered results.
// - Serves as the ALU logic slice and as a handshake teaching block for the ECE251 datapath labs.
// PARAMETERS
// - WIDTH   8   operand/result width in bits, 1..64
// - STAGES  2   pipeline register stages, 1..4; result latency in cycles
// - CNT_W   16  width of the delivered-result counter
// PORTS
// - clk        in   1      rising-edge clock, single clock domain
// - rst_n      in   1      synchronous, active-low reset
// - in_valid   in   1      upstream presents a, b, op
// - in_ready   out  1      block accepts the upstream beat this cycle
// - in_a       in   WIDTH  operand A
// - in_b       in   WIDTH  operand B
// - in_op      in   3      op_e code (see BEHAVIOUR)
// - out_valid  out  1      result beat present
// - out_ready  in   1      downstream accepts the result
// - out_y      out  WIDTH  result
// - out_zero   out  1      out_y == 0
// - out_par    out  1      XOR-reduction of out_y
// - res_count  out  CNT_W  number of delivered results, saturating
// BEHAVIOUR
// - Reset: when rst_n==0 at a clk edge, every stage valid, out_valid, out_y, out_zero, out_par and res_count go to 0.
//   - In-flight beats are discarded; a reset mid-operation never emits a partial beat.
//   - in_ready is 1 from the first cycle after reset.
// - Ops (in_op):
//   - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR: bitwise on a and b.
//   - 6 NOT_A = ~a.
//   - 7 PASS_A = a; b is ignored.
//   - All 8 codes are legal.
// - Transfer rule: a beat moves on any edge where valid && ready at that interface.
//   - in_valid may not depend on in_ready.
// - Compute point:
//   - The result is computed combinationally from in_a/in_b/in_op and captured in stage 1.
//   - Later stages are pure registers.
//   - Flags are computed from the stage-1 result and travel with it.
// - Stage ready:
//   - ready[i] = !valid[i] || ready[i+1]; ready[STAGES] = out_ready; in_ready = ready[1].
//   - The ready chain is combinational; no bubble is inserted.
// - Latency: an accepted beat appears on out_* exactly STAGES cycles later if there is no stall.
// - Throughput: 1 beat/cycle while out_ready==1.
// - Stall:
//   - While out_valid && !out_ready, out_y/out_zero/out_par hold stable.
//   - The pipe fills, then in_ready falls.
// - Full pipe with simultaneous in and out handshake: both complete and occupancy is unchanged.
// - Empty: out_valid==0, and out_y holds its last value; consumers must not sample it.
// - res_count:
//   - Increments on out_valid && out_ready.
//   - Saturates at 2^CNT_W-1; it never wraps.
// - Data registers load only when the stage accepts a beat; valid bits load every cycle.
// STRUCTURE
// - Shared package logic_pkg:
//   - typedef enum logic [2:0] op_e {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT_A, OP_PASS_A}
//   - localparam OP_W = 3
// - Sub-module pipe_stage #(DW):
//   - One valid/ready register slice.
//   - Ports: clk, rst_n, i_valid, i_ready, i_data, o_valid, o_ready, o_data.
//   - logic_unit_pipe generates STAGES instances with DW = WIDTH+2 ({par, zero, y}).
// - The op mux is a single always_comb case on op_e in the top module.
// TESTING
// - Reset then all ops, WIDTH=8, a=8'hC3, b=8'h5A, out_ready=1:
//   - y = 42, DB, 99, BD, 24, 66, 3C, C3 in that order.
//   - Each result appears 2 cycles after its accept; res_count ends at 8.
// - Flags:
//   - XOR a=b=8'hA5 -> y=00, out_zero=1, out_par=0.
//   - OR a=8'h01, b=8'h00 -> out_zero=0, out_par=1.
// - Backpressure:
//   - Stream 6 beats with out_ready=0 -> in_ready falls after 2 accepts; out_y is stable.
//   - Release out_ready -> all 6 beats arrive in order with no loss or duplicate.
// - Full throughput with out_ready toggling 1010 every cycle:
//   - Every beat is delivered exactly once.
//   - Count matches a scoreboard.
// - Reset mid-operation:
//   - Assert rst_n=0 for 1 cycle with 2 beats in flight.
//   - Next cycle: out_valid=0, res_count=0, in_ready=1; the dropped beats never appear.
// - Saturation: CNT_W=4, deliver 20 beats -> res_count sticks at 4'hF.

Source files
------------

// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

endpackage

// File: rtl/logic_unit_pipe_stage.sv
// One valid/ready register slice. The ready path is combinational, so a full
// slice still accepts a new beat in the same cycle its current beat leaves.
module pipe_stage #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data
);

    assign i_ready = !o_valid || o_ready;

    // Valid reloads every cycle; data only moves on an accepted beat so a
    // stalled or empty slice keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= i_valid || (o_valid && !o_ready);
            if (i_valid && i_ready)
                o_data <= i_data;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: op mux feeding STAGES valid/ready slices,
// with zero/parity flags carried alongside the result and a saturating
// delivered-result counter.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_par,
    output logic [CNT_W-1:0] res_count
);

    // Payload layout through the pipe: {par, zero, y}
    localparam int DW = WIDTH + 2;

    logic [WIDTH-1:0] y_c;
    op_e              op;

    logic             vld_pipe [STAGES:0];
    logic             rdy_pipe [STAGES:0];
    logic [DW-1:0]    dat_pipe [STAGES:0];

    assign op = op_e'(in_op);

    // Result is formed here, before stage 1; later stages only carry it.
    always_comb begin
        y_c = '0;
        case (op)
            OP_AND:    y_c = in_a & in_b;
            OP_OR:     y_c = in_a | in_b;
            OP_XOR:    y_c = in_a ^ in_b;
            OP_NAND:   y_c = ~(in_a & in_b);
            OP_NOR:    y_c = ~(in_a | in_b);
            OP_XNOR:   y_c = ~(in_a ^ in_b);
            OP_NOT_A:  y_c = ~in_a;
            OP_PASS_A: y_c = in_a;
            default:   y_c = '0;
        endcase
    end

    assign vld_pipe[0]      = in_valid;
    assign dat_pipe[0]      = {^y_c, (y_c == '0), y_c};
    assign rdy_pipe[STAGES] = out_ready;
    assign in_ready         = rdy_pipe[0];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage #(.DW(DW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (vld_pipe[g]),
            .i_ready (rdy_pipe[g]),
            .i_data  (dat_pipe[g]),
            .o_valid (vld_pipe[g+1]),
            .o_ready (rdy_pipe[g+1]),
            .o_data  (dat_pipe[g+1])
        );
    end

    assign out_valid                 = vld_pipe[STAGES];
    assign {out_par, out_zero, out_y} = dat_pipe[STAGES];

    // Count delivered beats, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n)
            res_count <= '0;
        else if (out_valid && out_ready && (res_count != '1))
            res_count <= res_count + 1'b1;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: op table, flags, backpressure,
// toggling ready, mid-flight reset and counter saturation.
module tb_logic_unit_pipe;

    localparam int STAGES = 2;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
        logic       z;
        logic       p;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic       p;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_zero;
    logic       out_par;
    logic [15:0] res_count;

    logic       sat_in_ready;
    logic       sat_out_valid;
    logic [7:0] sat_out_y;
    logic       sat_out_zero;
    logic       sat_out_par;
    logic [3:0] sat_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   delivered = 0;
    bit   acc;
    bit   stall_prev = 0;
    logic [7:0] prev_y;
    logic [7:0] nx_y;
    logic       nx_z;
    logic       nx_p;
    exp_t sb[$];
    vec_t tbl[10];
    vec_t beats[20];

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
        .out_par(out_par), .res_count(res_count)
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(STAGES), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_y(sat_out_y), .out_zero(sat_out_zero),
        .out_par(sat_out_par), .res_count(sat_count)
    );

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.a  = 8'($urandom);
        v.b  = 8'($urandom);
        v.op = 3'($urandom_range(0, 7));
        v.y  = model(v.a, v.b, v.op);
        v.z  = (v.y == 8'h00);
        v.p  = ^v.y;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_a = v.a; in_b = v.b; in_op = v.op;
        nx_y = v.y; nx_z = v.z; nx_p = v.p;
    endtask

    // One clock: settle, check any delivery and stall stability, record any
    // accept into the scoreboard, then advance to the next falling edge.
    task automatic cycle(input bit chk_lat);
        exp_t e;
        #1;
        acc = 1'b0;
        if (rst_n) begin
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_y", out_y, prev_y);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat act=%0h exp=none", out_y);
                end else begin
                    e = sb.pop_front();
                    chk("out_y", out_y, e.y);
                    chk("out_zero", out_zero, e.z);
                    chk("out_par", out_par, e.p);
                    if (chk_lat) chk("latency", cyc - e.cyc, STAGES);
                    delivered++;
                end
            end
            if (in_valid && in_ready) begin
                e.y = nx_y; e.z = nx_z; e.p = nx_p; e.cyc = cyc;
                sb.push_back(e);
                acc = 1'b1;
            end
            stall_prev = out_valid && !out_ready;
            prev_y = out_y;
        end else begin
            stall_prev = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input bit chk_lat);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && sb.size() > 0; i++) cycle(chk_lat);
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic stream(input int n);
        int idx = 0;
        for (int c = 0; c < 200 && idx < n; c++) begin
            drive(beats[idx]);
            cycle(1'b0);
            if (acc) idx++;
        end
        chk("stream_accepts", idx, n);
    endtask

    initial begin
        int idx;
        int d0;

        tbl[0] = '{8'hC3, 8'h5A, 3'd0, 8'h42, 1'b0, 1'b0};
        tbl[1] = '{8'hC3, 8'h5A, 3'd1, 8'hDB, 1'b0, 1'b0};
        tbl[2] = '{8'hC3, 8'h5A, 3'd2, 8'h99, 1'b0, 1'b0};
        tbl[3] = '{8'hC3, 8'h5A, 3'd3, 8'hBD, 1'b0, 1'b0};
        tbl[4] = '{8'hC3, 8'h5A, 3'd4, 8'h24, 1'b0, 1'b0};
        tbl[5] = '{8'hC3, 8'h5A, 3'd5, 8'h66, 1'b0, 1'b0};
        tbl[6] = '{8'hC3, 8'h5A, 3'd6, 8'h3C, 1'b0, 1'b0};
        tbl[7] = '{8'hC3, 8'h5A, 3'd7, 8'hC3, 1'b0, 1'b0};
        tbl[8] = '{8'hA5, 8'hA5, 3'd2, 8'h00, 1'b1, 1'b0};
        tbl[9] = '{8'h01, 8'h00, 3'd1, 8'h01, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        out_ready = 1'b1; nx_y = '0; nx_z = 1'b0; nx_p = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_y", out_y, 8'h00);
        chk("rst_out_zero", out_zero, 1'b0);
        chk("rst_out_par", out_par, 1'b0);
        chk("rst_res_count", res_count, 16'h0);
        chk("rst_in_ready", in_ready, 1'b1);

        // All ops plus flag vectors, back to back, latency checked
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            cycle(1'b1);
            chk("ops_accept", acc, 1'b1);
        end
        drain(1'b1);
        chk("ops_count", res_count, 16'd8);
        for (int i = 8; i < 10; i++) begin
            drive(tbl[i]);
            cycle(1'b1);
        end
        drain(1'b1);
        chk("flags_count", res_count, 16'd10);

        // Backpressure: 6 beats against a blocked output
        for (int i = 0; i < 6; i++) beats[i] = rand_vec();
        d0 = delivered;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 6) drive(beats[idx]);
            cycle(1'b0);
            if (acc) idx++;
        end
        #1;
        chk("bp_accepts", idx, 2);
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            drive(beats[idx]);
            cycle(1'b0);
            if (acc) idx++;
        end
        drain(1'b0);
        chk("bp_delivered", delivered - d0, 6);
        chk("bp_count", res_count, 16'(delivered));

        // Toggling out_ready 1010...
        for (int i = 0; i < 20; i++) beats[i] = rand_vec();
        d0 = delivered;
        idx = 0;
        for (int c = 0; c < 200 && idx < 20; c++) begin
            out_ready = ~cyc[0];
            drive(beats[idx]);
            cycle(1'b0);
            if (acc) idx++;
        end
        drain(1'b0);
        chk("tog_delivered", delivered - d0, 20);
        chk("tog_count", res_count, 16'(delivered));

        // Reset with 2 beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(rand_vec());
            cycle(1'b0);
        end
        chk("inflight", sb.size(), 2);
        rst_n = 1'b0;
        in_valid = 1'b0;
        cycle(1'b0);
        rst_n = 1'b1;
        sb.delete();
        delivered = 0;
        #1;
        chk("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_res_count", res_count, 16'h0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_sat_count", sat_count, 4'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0);
        chk("mrst_no_beat", res_count, 16'h0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) beats[i] = rand_vec();
        stream(14);
        drain(1'b0);
        chk("sat_main_14", res_count, 16'd14);
        chk("sat_cnt_14", sat_count, 4'hE);
        for (int i = 0; i < 6; i++) beats[i] = beats[i + 14];
        stream(6);
        drain(1'b0);
        chk("sat_main_20", res_count, 16'd20);
        chk("sat_cnt_20", sat_count, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
